stage_rx: RTL and testbench
===========================

STAGE_RX -- requirements
Module: stage_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter WIDTH, default 8, data word width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port DIR  input  1  upstream data-output-ready; held high with data_in until ack_prev seen.
REQ-006 SHALL have port data_in  input  WIDTH  upstream word, valid while DIR high.
REQ-007 SHALL have port ack_prev  output  1  registered one-cycle acknowledge to upstream.
REQ-008 SHALL have port rd_en  input  1  consumer pop request.
REQ-009 SHALL have port rd_data  output  WIDTH  FIFO head word, first-word-fall-through.
REQ-010 SHALL have port empty  output  1  FIFO holds zero words.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH words.
REQ-012 SHALL have port count  output  clog2(DEPTH)+1  words held, 0..DEPTH.
REQ-013 SHALL have port underflow  output  1  sticky: rd_en seen while empty.
REQ-014 SHALL have port checksum  output  WIDTH  running modulo-2^WIDTH sum of accepted words.

Function
REQ-015 SHALL implement receive FSM with states IDLE, ACK, WAIT_DROP.
REQ-016 IDLE: DIR=1 and full=0 -> write data_in at tail, ack_prev<=1, go ACK, all at same edge.
REQ-017 IDLE: DIR=1 and full=1 -> no write, ack_prev stays 0, remain IDLE (backpressure; upstream holds word).
REQ-018 IDLE: full evaluated from registered count before any same-cycle pop; pop in that cycle does not enable the write.
REQ-019 ACK: ack_prev<=0 unconditionally, go WAIT_DROP; DIR ignored.
REQ-020 WAIT_DROP: DIR=0 -> go IDLE; DIR=1 -> remain, no write (no duplicate capture of held word).
REQ-021 ack_prev SHALL be high for exactly one cycle per accepted word; minimum 3 cycles between accepts.
REQ-022 rd_data SHALL equal head entry combinationally when empty=0; value when empty=1 is don't-care (bench checks only when non-empty).
REQ-023 rd_en=1 and empty=0 -> head pointer advances at edge; rd_en=1 and empty=1 -> no pointer change, underflow<=1.
REQ-024 Simultaneous write and pop: count unchanged, both pointers advance.
REQ-025 Pointers SHALL wrap modulo DEPTH; full/empty derived from count, never from pointer equality alone.
REQ-026 Words SHALL leave in acceptance order; no loss, no duplication.

Reset
REQ-027 reset=1 at an edge -> FSM IDLE, pointers 0, count 0, ack_prev 0, underflow 0, checksum 0; empty=1, full=0 next cycle.
REQ-028 Reset mid-handshake (ACK or WAIT_DROP) -> ack_prev low after that edge, buffered words discarded; a still-high DIR after reset is accepted as new word.
REQ-029 reset SHALL dominate DIR and rd_en in the same cycle.

Configuration
REQ-030 Macro STAGE_RX_CHECKSUM_EN defined -> checksum<=checksum+data_in on every accepting edge (REQ-016), wraps modulo 2^WIDTH.
REQ-031 Macro STAGE_RX_CHECKSUM_EN undefined -> checksum port constant 0, no adder or register instantiated; all other behaviour identical.

Verification
REQ-032 Single transfer: DIR=1, data_in=8'h2A from IDLE, empty -> ack_prev high exactly one cycle after edge 1, count=1, rd_data=8'h2A, empty=0.
REQ-033 Held DIR: DIR stays high 5 cycles with 8'h10 -> exactly one write, one ack pulse, count=1.
REQ-034 Fill/backpressure: accept 8'h01..8'h04 (DEPTH=4), present 8'h05 -> full=1, no ack; pop once -> 8'h05 accepted, pops yield 02,03,04,05 in order.
REQ-035 Underflow: rd_en=1 while empty -> count stays 0, underflow=1 and sticky until reset.
REQ-036 Checksum (macro defined): accept 8'hF0, 8'h20, 8'h05 -> checksum=8'h15; macro undefined -> checksum=0.
REQ-037 Reset during ACK after accepting 8'h33 -> ack_prev 0, count 0, empty 1 next cycle.

Source files
------------

// File: rtl/stage_rx.sv
// stage_rx: DIR/ack receive handshake feeding a first-word-fall-through FIFO.
// Latency: word visible on rd_data the cycle after the accepting edge; ack_prev pulses one cycle.
// Backpressure: while full, DIR is left unacknowledged and upstream holds its word.
//
// Ports:
//   clk, reset      single rising-edge clock, synchronous active-high reset
//   DIR, data_in    upstream word offer (held until ack_prev)
//   ack_prev        registered one-cycle acknowledge to upstream
//   rd_en, rd_data  consumer pop request / head word (valid while empty=0)
//   empty, full     occupancy flags derived from count
//   count           words held, 0..DEPTH
//   underflow       sticky flag: pop requested while empty
//   checksum        modulo-2^WIDTH sum of accepted words
// Optional feature macro: STAGE_RX_CHECKSUM_EN (undefined -> checksum tied to 0).
module stage_rx #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       DIR,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       ack_prev,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow,
  output logic [WIDTH-1:0]           checksum
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ack_q, ack_d;
  logic              underflow_q, underflow_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              wr_en;
  logic              pop;

  // Flags come from the registered count only, so a same-cycle pop never
  // opens room for a write in that cycle.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign ack_prev  = ack_q;
  assign underflow = underflow_q;
  assign rd_data   = mem_q[rd_ptr_q];

  // Receive FSM: one capture per DIR assertion; WAIT_DROP blocks re-capture
  // of the held word until upstream drops DIR.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (DIR && !full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!DIR) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = rd_en && !empty;
    underflow_d = underflow_q | (rd_en && empty);
    wr_ptr_d    = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (wr_en && !pop) count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ack_q       <= ack_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only observable once written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef STAGE_RX_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (wr_en) checksum_d = checksum_q + data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_stage_rx.sv
// tb_stage_rx: directed-vector bench for stage_rx (DEPTH=4, WIDTH=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_stage_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       dir;
  logic [7:0] data_in;
  logic       ack_prev;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       underflow;
  logic [7:0] checksum;

  int n_chk  = 0;
  int n_fail = 0;

  stage_rx #(.DEPTH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .DIR       (dir),
    .data_in   (data_in),
    .ack_prev  (ack_prev),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .underflow (underflow),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dir   = 1'b0;
    rd_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Offer one word, wait (bounded) for its ack, then drop DIR and let the
  // FSM return to IDLE (ACK -> WAIT_DROP -> IDLE).
  task automatic send(input logic [7:0] w, input string tag);
    dir     = 1'b1;
    data_in = w;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_prev) break;
    end
    chk(tag, ack_prev, 1);
    dir = 1'b0;
    tick();
    tick();
  endtask

  int acks;
  logic [7:0] exp_pop [4];

  initial begin
    reset   = 1'b1;
    dir     = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ack", ack_prev, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_checksum", checksum, 0);

    // Single transfer
    dir = 1'b1; data_in = 8'h2A;
    tick();
    chk("single_ack", ack_prev, 1);
    chk("single_count", count, 1);
    chk("single_data", rd_data, 8'h2A);
    chk("single_empty", empty, 0);
    dir = 1'b0;
    tick();
    chk("single_ack_low", ack_prev, 0);
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("single_pop_empty", empty, 1);

    // Held DIR: exactly one capture
    dir = 1'b1; data_in = 8'h10;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack_prev) acks++;
    end
    chk("held_acks", acks, 1);
    chk("held_count", count, 1);
    chk("held_data", rd_data, 8'h10);
    dir = 1'b0;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("held_pop_count", count, 0);

    // Fill and backpressure (pointers wrap on the fifth write)
    send(8'h01, "fill_ack1");
    send(8'h02, "fill_ack2");
    send(8'h03, "fill_ack3");
    send(8'h04, "fill_ack4");
    chk("fill_full", full, 1);
    chk("fill_count", count, 4);
    dir = 1'b1; data_in = 8'h05;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack_prev) acks++;
    end
    chk("bp_no_ack", acks, 0);
    chk("bp_count", count, 4);
    chk("bp_head", rd_data, 8'h01);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("bp_pop_no_write", ack_prev, 0);
    chk("bp_pop_count", count, 3);
    tick();
    chk("bp_accept_ack", ack_prev, 1);
    chk("bp_accept_count", count, 4);
    dir = 1'b0;
    tick();
    tick();
    exp_pop[0] = 8'h02; exp_pop[1] = 8'h03; exp_pop[2] = 8'h04; exp_pop[3] = 8'h05;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("order_%0d", i), rd_data, exp_pop[i]);
      tick();
    end
    rd_en = 1'b0;
    chk("order_empty", empty, 1);
    chk("order_count", count, 0);

    // Underflow, sticky until reset
    chk("pre_underflow", underflow, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("uf_count", count, 0);
    chk("uf_flag", underflow, 1);
    send(8'h77, "uf_send_ack");
    tick();
    chk("uf_sticky", underflow, 1);
    do_reset();
    chk("uf_cleared", underflow, 0);

    // Checksum, then simultaneous write and pop
    send(8'hF0, "cs_ack1");
    send(8'h20, "cs_ack2");
    send(8'h05, "cs_ack3");
`ifdef STAGE_RX_CHECKSUM_EN
    chk("checksum", checksum, 8'h15);
`else
    chk("checksum", checksum, 8'h00);
`endif
    chk("cs_count", count, 3);
    dir = 1'b1; data_in = 8'hAA; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("wrpop_ack", ack_prev, 1);
    chk("wrpop_count", count, 3);
    chk("wrpop_head", rd_data, 8'h20);
    dir = 1'b0;
    tick();
    tick();

    // Reset during ACK; a still-high DIR afterwards is a new word
    do_reset();
    dir = 1'b1; data_in = 8'h33;
    tick();
    chk("rack_ack", ack_prev, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rack_ack_low", ack_prev, 0);
    chk("rack_count", count, 0);
    chk("rack_empty", empty, 1);
    tick();
    chk("rack_reaccept_ack", ack_prev, 1);
    chk("rack_reaccept_count", count, 1);
    chk("rack_reaccept_data", rd_data, 8'h33);
    dir = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
